attack_controller: RTL and testbench

Sequencing controller for the battleship attack phase. It sits between the game-state inputs and coordinates on one side and the matrix/LED path on the other. It latches the selected ship map when preparation ends and converts debounced attack confirmations into one-shot evaluations. It also keeps the shot and hit maps, counts remaining shots, and declares victory or defeat. Its outputs drive the attack image on the 5x7 matrix and the RGB LED.

---
 rtl/attack_controller.sv | 167 ++++++++++++++++
 tb/tb_attack_controller.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/attack_controller.sv
// Attack-phase sequencer for the battleship game: latches the ship map, turns confirm edges into
// single-cycle shot evaluations, tracks shot/hit maps and declares victory or defeat.
module attack_controller #(
  parameter int unsigned M_COLUNE_SIZE   = 7,
  parameter int unsigned M_TOTAL_COLUNES = 5,
  parameter int unsigned M_DATA_WIDTH    = 35,
  parameter int unsigned MAX_SHOTS       = 12
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [1:0]              game_state_code,
  input  logic [M_DATA_WIDTH-1:0] selected_map,
  input  logic [2:0]              x_coord_code,
  input  logic [2:0]              y_coord_code,
  input  logic                    confirm_attack,
  output logic [M_DATA_WIDTH-1:0] shot_map,
  output logic [M_DATA_WIDTH-1:0] hit_map,
  output logic [5:0]              shots_left,
  output logic [5:0]              hits,
  output logic [1:0]              ledRgb,
  output logic                    game_over
);

  typedef enum logic [2:0] {StOff, StPrep, StArmed, StEval, StWon, StLost} state_e;

  localparam logic [5:0] MaxShots = 6'(MAX_SHOTS);

  state_e                  state;
  logic [M_DATA_WIDTH-1:0] target;
  logic [5:0]              ship_cells;
  logic [2:0]              x_q;
  logic [2:0]              y_q;
  logic                    confirm_q;

  logic       code_off;
  logic       rise;
  logic       valid;
  logic [5:0] idx;
  logic       already_shot;
  logic       consume;
  logic       is_hit;
  logic [5:0] new_hits;
  logic [5:0] new_shots;

  function automatic logic [5:0] popcount(input logic [M_DATA_WIDTH-1:0] v);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < int'(M_DATA_WIDTH); i++) c = c + 6'(v[i]);
    return c;
  endfunction

  always_comb begin
    code_off     = (game_state_code == 2'b00) || (game_state_code == 2'b11);
    rise         = confirm_attack & ~confirm_q;
    valid        = (32'(x_q) < M_TOTAL_COLUNES) && (32'(y_q) < M_COLUNE_SIZE);
    idx          = {3'b000, x_q} * 6'(M_COLUNE_SIZE) + {3'b000, y_q};
    already_shot = valid ? shot_map[idx] : 1'b0;
    // shots_left > 0 keeps the counter from wrapping
    consume      = valid && !already_shot && (shots_left != 6'd0);
    is_hit       = consume && target[idx];
    new_hits     = hits + 6'(is_hit);
    new_shots    = consume ? shots_left - 6'd1 : shots_left;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= StOff;
      target     <= '0;
      ship_cells <= '0;
      x_q        <= '0;
      y_q        <= '0;
      confirm_q  <= 1'b0;
      shot_map   <= '0;
      hit_map    <= '0;
      shots_left <= '0;
      hits       <= '0;
      ledRgb     <= 2'b00;
      game_over  <= 1'b0;
    end else begin
      confirm_q <= confirm_attack;
      if (code_off) begin
        state      <= StOff;
        target     <= '0;
        ship_cells <= '0;
        shot_map   <= '0;
        hit_map    <= '0;
        shots_left <= '0;
        hits       <= '0;
        ledRgb     <= 2'b00;
        game_over  <= 1'b0;
      end else begin
        unique case (state)
          StOff: begin
            if (game_state_code == 2'b01) state <= StPrep;
          end
          StPrep: begin
            shot_map   <= '0;
            hit_map    <= '0;
            hits       <= '0;
            ledRgb     <= 2'b00;
            game_over  <= 1'b0;
            shots_left <= MaxShots;
            target     <= selected_map;
            ship_cells <= popcount(selected_map);
            if (game_state_code == 2'b10) state <= StArmed;
          end
          StArmed: begin
            if (game_state_code == 2'b01) begin
              state <= StPrep;
            end else if (ship_cells == 6'd0) begin
              state     <= StWon;
              ledRgb    <= 2'b10;
              game_over <= 1'b1;
            end else if (rise) begin
              x_q   <= x_coord_code;
              y_q   <= y_coord_code;
              state <= StEval;
            end
          end
          StEval: begin
            if (!consume) begin
              ledRgb <= 2'b11;
            end else begin
              shot_map[idx] <= 1'b1;
              shots_left    <= new_shots;
              if (is_hit) begin
                hit_map[idx] <= 1'b1;
                hits         <= new_hits;
                ledRgb       <= 2'b10;
              end else begin
                ledRgb <= 2'b01;
              end
            end
            // a win on the final shot takes precedence over running out
            if (new_hits == ship_cells) begin
              state     <= StWon;
              game_over <= 1'b1;
            end else if (new_shots == 6'd0) begin
              state     <= StLost;
              game_over <= 1'b1;
            end else begin
              state <= StArmed;
            end
          end
          StWon: begin
            if (game_state_code == 2'b01) begin
              state <= StPrep;
            end else begin
              ledRgb    <= 2'b10;
              game_over <= 1'b1;
            end
          end
          StLost: begin
            if (game_state_code == 2'b01) begin
              state <= StPrep;
            end else begin
              ledRgb    <= 2'b01;
              game_over <= 1'b1;
            end
          end
          default: state <= StOff;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_attack_controller.sv
// Directed bench for attack_controller: linear stimulus, hand-computed expectations.
module tb_attack_controller;

  logic        clk;
  logic        reset;
  logic [1:0]  game_state_code;
  logic [34:0] selected_map;
  logic [2:0]  x_coord_code;
  logic [2:0]  y_coord_code;
  logic        confirm_attack;
  logic [34:0] shot_map;
  logic [34:0] hit_map;
  logic [5:0]  shots_left;
  logic [5:0]  hits;
  logic [1:0]  ledRgb;
  logic        game_over;

  int compared   = 0;
  int mismatched = 0;

  attack_controller dut (
    .clk             (clk),
    .reset           (reset),
    .game_state_code (game_state_code),
    .selected_map    (selected_map),
    .x_coord_code    (x_coord_code),
    .y_coord_code    (y_coord_code),
    .confirm_attack  (confirm_attack),
    .shot_map        (shot_map),
    .hit_map         (hit_map),
    .shots_left      (shots_left),
    .hits            (hits),
    .ledRgb          (ledRgb),
    .game_over       (game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Confirm rises at edge k (-> EVAL), falls before edge k+1 (results visible after k+1).
  task automatic shoot(input logic [2:0] x, input logic [2:0] y);
    x_coord_code   = x;
    y_coord_code   = y;
    confirm_attack = 1'b1;
    tick();
    confirm_attack = 1'b0;
    tick();
  endtask

  task automatic start_game(input logic [34:0] map);
    selected_map    = map;
    game_state_code = 2'b01;
    tick();
    game_state_code = 2'b10;
    tick();
  endtask

  initial begin
    reset           = 1'b1;
    game_state_code = 2'b00;
    selected_map    = '0;
    x_coord_code    = '0;
    y_coord_code    = '0;
    confirm_attack  = 1'b0;
    tick();
    tick();
    check("reset_shots_left", 64'(shots_left), 64'd0);
    check("reset_game_over", 64'(game_over), 64'd0);
    reset = 1'b0;
    tick();

    // Game A: three misses, then asynchronous reset mid-game
    start_game(35'h0 | (35'd1 << 9) | (35'd1 << 30));
    check("a_armed_shots", 64'(shots_left), 64'd12);
    shoot(3'd0, 3'd0);
    shoot(3'd0, 3'd1);
    shoot(3'd0, 3'd2);
    check("a_three_misses_shots", 64'(shots_left), 64'd9);
    check("a_three_misses_map", 64'(shot_map), 64'h7);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("a_async_reset_map", 64'(shot_map), 64'd0);
    check("a_async_reset_shots", 64'(shots_left), 64'd0);
    game_state_code = 2'b00;
    tick();
    reset = 1'b0;
    tick();
    check("a_post_reset_led", 64'(ledRgb), 64'd0);
    check("a_post_reset_over", 64'(game_over), 64'd0);

    // Game B: confirm held across PREP->ARMED, then held through a shot
    confirm_attack = 1'b1;
    start_game(35'd1 << 9);
    check("b_start_shots", 64'(shots_left), 64'd12);
    check("b_start_hits", 64'(hits), 64'd0);
    tick();
    tick();
    check("b_held_level_no_shot", 64'(shots_left), 64'd12);
    confirm_attack = 1'b0;
    tick();
    x_coord_code   = 3'd0;
    y_coord_code   = 3'd0;
    confirm_attack = 1'b1;
    tick();
    tick();
    tick();
    tick();
    check("b_held_single_shot", 64'(shots_left), 64'd11);
    check("b_miss_led", 64'(ledRgb), 64'b01);
    confirm_attack = 1'b0;
    tick();
    shoot(3'd0, 3'd0);
    check("b_repeat_led", 64'(ledRgb), 64'b11);
    check("b_repeat_shots", 64'(shots_left), 64'd11);
    shoot(3'd5, 3'd0);
    check("b_invalid_led", 64'(ledRgb), 64'b11);
    check("b_invalid_shots", 64'(shots_left), 64'd11);
    check("b_invalid_map", 64'(shot_map), 64'h1);
    selected_map = '0;
    shoot(3'd1, 3'd2);
    check("b_hit_map", 64'(hit_map), 64'h200);
    check("b_hit_hits", 64'(hits), 64'd1);
    check("b_hit_shots", 64'(shots_left), 64'd10);
    check("b_hit_led", 64'(ledRgb), 64'b10);
    check("b_shot_map", 64'(shot_map), 64'h201);
    tick();
    check("b_won_over", 64'(game_over), 64'd1);
    check("b_won_led", 64'(ledRgb), 64'b10);
    shoot(3'd2, 3'd2);
    check("b_won_ignores_confirm", 64'(shot_map), 64'h201);

    // Game C: restart from WON, exhaust all 12 shots on misses
    game_state_code = 2'b01;
    selected_map    = 35'd1 << 34;
    tick();
    tick();
    check("c_restart_hit_map", 64'(hit_map), 64'd0);
    check("c_restart_over", 64'(game_over), 64'd0);
    game_state_code = 2'b10;
    tick();
    for (int i = 0; i < 11; i++) shoot(3'(i / 7), 3'(i % 7));
    check("c_eleven_shots", 64'(shots_left), 64'd1);
    check("c_eleven_over", 64'(game_over), 64'd0);
    shoot(3'd1, 3'd4);
    check("c_lost_shots", 64'(shots_left), 64'd0);
    check("c_lost_over", 64'(game_over), 64'd1);
    check("c_lost_led", 64'(ledRgb), 64'b01);
    check("c_lost_map", 64'(shot_map), 64'hFFF);
    shoot(3'd2, 3'd0);
    check("c_13th_map", 64'(shot_map), 64'hFFF);
    check("c_13th_led", 64'(ledRgb), 64'b01);

    // Game D: code 01 from LOST, then an empty map wins immediately
    game_state_code = 2'b01;
    selected_map    = '0;
    tick();
    tick();
    check("d_from_lost_map", 64'(shot_map), 64'd0);
    check("d_from_lost_shots", 64'(shots_left), 64'd12);
    check("d_from_lost_led", 64'(ledRgb), 64'd0);
    game_state_code = 2'b10;
    tick();
    check("d_armed_not_over", 64'(game_over), 64'd0);
    tick();
    check("d_empty_won_over", 64'(game_over), 64'd1);
    check("d_empty_won_led", 64'(ledRgb), 64'b10);

    // Game E: code 00 during EVAL discards the pending shot
    game_state_code = 2'b00;
    tick();
    start_game(35'd1 << 9);
    x_coord_code    = 3'd1;
    y_coord_code    = 3'd2;
    confirm_attack  = 1'b1;
    tick();
    game_state_code = 2'b00;
    confirm_attack  = 1'b0;
    tick();
    check("e_off_hit_map", 64'(hit_map), 64'd0);
    check("e_off_hits", 64'(hits), 64'd0);
    check("e_off_shots", 64'(shots_left), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
